snd_cmd_fifo: RTL and testbench
===============================

# snd_cmd_fifo

Sound-command mailbox between the main CPU and the sound CPU. It is the receiving end of the main CPU's `snd_write` path. Main-CPU writes are turned into single push events and queued in a small FIFO. The block raises an interrupt to the sound CPU while commands are pending and hands out one byte per sound-CPU read. It sits in the audio subsystem, between the address decoder's `snd_write` / `mcpu_dout` and the sound CPU's data bus and IRQ input.

## Interface
Parameters:
- DEPTH, 4: number of command entries; power of two, 2..16.
- WIDTH, 8: command width in bits.

Ports:
- clk_sys  in  1  system clock; every register is clocked on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- snd_write  in  1  main-CPU write strobe; a level that may stay high for many clk_sys cycles.
- mcpu_dout  in  WIDTH  main-CPU write data; valid whenever snd_write is high.
- scpu_rd  in  1  sound-CPU read strobe of the command port; a level that may be held.
- ovf_clear  in  1  synchronous clear of the sticky overflow flag.
- cmd_out  out  WIDTH  head-of-queue byte, registered.
- irq  out  1  high while at least one command is pending, registered.
- count  out  $clog2(DEPTH)+1  number of pending entries.
- overflow  out  1  sticky; set when a push is dropped because the FIFO is full.

## Operation
- Push event (`push`): rising edge of snd_write, i.e. sampled high this cycle and low in the previous sample. Exactly one push per strobe, however long the strobe is held.
- Pop event (`pop`): rising edge of scpu_rd, detected the same way.
- Push when count < DEPTH:
  - write mcpu_dout at wr_ptr;
  - wr_ptr += 1, wrapping modulo DEPTH;
  - count += 1.
- Push when count == DEPTH:
  - data is dropped;
  - overflow is set to 1;
  - pointers and count are unchanged.
- Pop when count > 0: rd_ptr += 1 (modulo DEPTH), count -= 1.
- Pop when count == 0: ignored; no state changes and overflow is not affected.
- Push and pop in the same cycle:
  - count 0: only the push takes effect; count becomes 1.
  - count DEPTH: both take effect; the push is accepted and count stays DEPTH.
  - any other count: both take effect and count is unchanged.
- cmd_out is registered and always holds the entry at rd_ptr after the update.
  - A pop that leaves the FIFO empty keeps the last popped byte, so the sound CPU re-reading the port sees latch-like behaviour.
  - A push into an empty FIFO loads cmd_out with the pushed byte.
- irq = (count_next != 0), registered.
- overflow:
  - cleared by ovf_clear;
  - if ovf_clear and an overflowing push occur in the same cycle, set wins.

## Timing
- Reset (asynchronous assert, synchronous deassert is the parent's job) sets:
  - wr_ptr = 0, rd_ptr = 0, count = 0;
  - cmd_out = 0, irq = 0, overflow = 0;
  - both edge-detect history flops = 1, so a strobe held high across reset release produces no event.
  - Storage array contents are not reset.
- Latency: at the clock edge E where push is detected, cmd_out (if the FIFO was empty), count and irq are all updated. They are visible in cycle E+1.
- Pop at edge E: cmd_out shows the next entry, count decrements and irq falls (if the FIFO becomes empty), all in cycle E+1.
- Minimum strobe: high for one cycle, then low for at least one cycle, before a new event can be detected.
- Reset asserted mid-operation: all queued commands are discarded and outputs return to their reset values immediately, without waiting for a clock.

## Structure
- Package `snd_pkg`:
  - localparam SND_DEPTH = 4;
  - localparam SND_W = 8;
  - typedef logic [SND_W-1:0] snd_cmd_t.
- Sub-module `edge_rise`: one history flop (reset value 1) plus an AND gate; output pulse = in & ~prev. Instantiated twice, once for snd_write and once for scpu_rd.
- Storage: a DEPTH x WIDTH register array, written on accepted push. cmd_out is loaded from the array or, on push-to-empty, directly from mcpu_dout.

## Test plan
- Reset, then single command: snd_write high for 5 cycles with mcpu_dout=0x3C -> exactly one push; count=1, irq=1, cmd_out=0x3C one cycle after the first high sample. Then pulse scpu_rd -> count=0, irq=0, cmd_out stays 0x3C.
- Fill and overflow: push 0x01,0x02,0x03,0x04,0x05 -> count=4, overflow=1. Four pops return 0x01..0x04 in order; count=0 and irq=0 after the fourth pop.
- Simultaneous full: with count=4 (0x10..0x13), push 0x14 and pop in the same cycle -> count=4, overflow unchanged. Subsequent pops return 0x11,0x12,0x13,0x14.
- Simultaneous empty: with count=0, push 0xA5 and pop in the same cycle -> count=1, cmd_out=0xA5, irq=1.
- Pointer wrap: run 10 push/pop pairs with values 0..9 -> each pop returns the value just pushed; pointers wrap cleanly past DEPTH.
- Reset mid-operation: with count=3, assert reset_n=0 -> count=0, irq=0, cmd_out=0 immediately. Release reset with snd_write still held high -> no push until snd_write goes low and high again.
- Overflow clear: with overflow=1, assert ovf_clear together with a push to a full FIFO -> overflow stays 1. Assert ovf_clear alone -> overflow=0.

Source files
------------

// File: rtl/snd_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | snd_pkg : shared sizes and command type for the sound mailbox   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package snd_pkg;
    localparam int SND_DEPTH = 4;
    localparam int SND_W     = 8;

    typedef logic [SND_W-1:0] snd_cmd_t;
endpackage
`default_nettype wire

// File: rtl/snd_cmd_fifo_edge_rise.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | edge_rise : one-cycle pulse on a rising level of sig_in         |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic pulse
);
    logic r_prev;

    // History resets high so a level held through reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_prev <= 1'b1;
        else        r_prev <= sig_in;
    end

    assign pulse = sig_in & ~r_prev;
endmodule
`default_nettype wire

// File: rtl/snd_cmd_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | snd_cmd_fifo : main-CPU to sound-CPU command mailbox with IRQ   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module snd_cmd_fifo
    import snd_pkg::*;
#(
    parameter int DEPTH = SND_DEPTH,
    parameter int WIDTH = SND_W
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    input  logic                       snd_write,
    input  logic [WIDTH-1:0]           mcpu_dout,
    input  logic                       scpu_rd,
    input  logic                       ovf_clear,
    output logic [WIDTH-1:0]           cmd_out,
    output logic                       irq,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic             w_push, w_pop;
    logic             w_push_en, w_pop_en, w_ovf_set;
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr, w_rd_next;
    logic [CW-1:0]    r_count, w_count_next;
    logic [WIDTH-1:0] r_cmd;
    logic             r_irq, r_ovf;
    logic [WIDTH-1:0] r_mem [DEPTH];

    edge_rise u_push_edge (
        .clk    (clk_sys),
        .rst_n  (reset_n),
        .sig_in (snd_write),
        .pulse  (w_push)
    );

    edge_rise u_pop_edge (
        .clk    (clk_sys),
        .rst_n  (reset_n),
        .sig_in (scpu_rd),
        .pulse  (w_pop)
    );

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    always_comb begin
        w_pop_en     = w_pop && (r_count != '0);
        w_push_en    = w_push && ((r_count != C_FULL) || w_pop_en);
        w_ovf_set    = w_push && !w_push_en;
        w_rd_next    = w_pop_en ? r_rd_ptr + AW'(1) : r_rd_ptr;
        w_count_next = r_count + CW'(w_push_en) - CW'(w_pop_en);
    end

    always_ff @(posedge clk_sys) begin
        if (w_push_en) r_mem[r_wr_ptr] <= mcpu_dout;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_cmd    <= '0;
            r_irq    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_en) r_wr_ptr <= r_wr_ptr + AW'(1);
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            r_irq    <= (w_count_next != '0);
            // Head slot being written this cycle is not in the array yet: bypass it.
            // Going empty leaves the last byte latched.
            if (w_count_next != '0)
                r_cmd <= (w_push_en && (w_rd_next == r_wr_ptr)) ? mcpu_dout : r_mem[w_rd_next];
            if (w_ovf_set)      r_ovf <= 1'b1;
            else if (ovf_clear) r_ovf <= 1'b0;
        end
    end

    assign cmd_out  = r_cmd;
    assign irq      = r_irq;
    assign count    = r_count;
    assign overflow = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_snd_cmd_fifo.sv
`default_nettype none
// Testbench for snd_cmd_fifo: directed steps plus random traffic against a queue model.
module tb_snd_cmd_fifo;
    import snd_pkg::*;

    localparam int DEPTH = SND_DEPTH;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic           clk_sys = 1'b0;
    logic           reset_n = 1'b1;
    logic           snd_write = 1'b0;
    snd_cmd_t       mcpu_dout = '0;
    logic           scpu_rd = 1'b0;
    logic           ovf_clear = 1'b0;
    snd_cmd_t       cmd_out;
    logic           irq;
    logic [CW-1:0]  count;
    logic           overflow;

    int checks = 0;
    int errors = 0;

    snd_cmd_t q[$];
    bit       m_prev_w, m_prev_r, m_ovf;
    snd_cmd_t m_cmd;

    always #5 clk_sys = ~clk_sys;

    snd_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(SND_W)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .snd_write (snd_write),
        .mcpu_dout (mcpu_dout),
        .scpu_rd   (scpu_rd),
        .ovf_clear (ovf_clear),
        .cmd_out   (cmd_out),
        .irq       (irq),
        .count     (count),
        .overflow  (overflow)
    );

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        compare({tag, " count"},    32'(count),    32'(q.size()));
        compare({tag, " irq"},      32'(irq),      32'(q.size() != 0));
        compare({tag, " cmd_out"},  32'(cmd_out),  32'(m_cmd));
        compare({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic model_reset();
        q.delete();
        m_prev_w = 1'b1;
        m_prev_r = 1'b1;
        m_ovf    = 1'b0;
        m_cmd    = '0;
    endtask

    // Apply inputs for one clock, advance the model by one edge, then sample.
    task automatic cyc(input logic w, input snd_cmd_t d, input logic r, input logic c);
        bit pu, po;
        snd_write = w; mcpu_dout = d; scpu_rd = r; ovf_clear = c;
        pu = w && !m_prev_w;
        po = r && !m_prev_r;
        m_prev_w = w;
        m_prev_r = r;
        if (po && q.size() > 0) void'(q.pop_front());
        if (c) m_ovf = 1'b0;
        if (pu) begin
            if (q.size() < DEPTH) q.push_back(d);
            else                  m_ovf = 1'b1;
        end
        if (q.size() != 0) m_cmd = q[0];
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push(input snd_cmd_t d);
        cyc(1'b1, d, 1'b0, 1'b0);
        cyc(1'b0, d, 1'b0, 1'b0);
        check_all("push");
    endtask

    task automatic pop();
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check_all("pop");
    endtask

    initial begin
        #3 reset_n = 1'b0;
        #1;
        compare("reset count", 32'(count), 32'd0);
        compare("reset irq", 32'(irq), 32'd0);
        compare("reset cmd_out", 32'(cmd_out), 32'd0);
        compare("reset overflow", 32'(overflow), 32'd0);
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        model_reset();
        cyc(1'b0, '0, 1'b0, 1'b0);
        check_all("idle");

        // Long write strobe gives a single push.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'h3C, 1'b0, 1'b0);
            check_all("held_write");
        end
        compare("single push count", 32'(count), 32'd1);
        compare("single push cmd", 32'(cmd_out), 32'h3C);
        cyc(1'b0, '0, 1'b0, 1'b0);
        pop();
        compare("pop empty irq", 32'(irq), 32'd0);
        compare("latched cmd", 32'(cmd_out), 32'h3C);

        // Fill and overflow, then drain in order.
        for (int i = 1; i <= 5; i++) push(snd_cmd_t'(i));
        compare("fill count", 32'(count), 32'd4);
        compare("fill overflow", 32'(overflow), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            compare("drain order", 32'(cmd_out), 32'(i));
            pop();
        end
        compare("drained irq", 32'(irq), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        check_all("ovf_clear");
        compare("ovf cleared", 32'(overflow), 32'd0);

        // Simultaneous push and pop on a full FIFO.
        for (int i = 0; i < 4; i++) push(snd_cmd_t'(8'h10 + i));
        cyc(1'b1, 8'h14, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check_all("full_pushpop");
        compare("full pushpop count", 32'(count), 32'd4);
        compare("full pushpop overflow", 32'(overflow), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            compare("full pushpop order", 32'(cmd_out), 32'(8'h10 + i));
            pop();
        end

        // Simultaneous push and pop on an empty FIFO.
        cyc(1'b1, 8'hA5, 1'b1, 1'b0);
        check_all("empty_pushpop");
        compare("empty pushpop count", 32'(count), 32'd1);
        compare("empty pushpop cmd", 32'(cmd_out), 32'hA5);
        compare("empty pushpop irq", 32'(irq), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        pop();

        // Pointer wrap.
        for (int i = 0; i < 10; i++) begin
            push(snd_cmd_t'(i));
            compare("wrap value", 32'(cmd_out), 32'(i));
            pop();
        end

        // Asynchronous reset mid-operation with write strobe held across release.
        for (int i = 0; i < 3; i++) push(snd_cmd_t'(8'h60 + i));
        snd_write = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        compare("async reset count", 32'(count), 32'd0);
        compare("async reset irq", 32'(irq), 32'd0);
        compare("async reset cmd", 32'(cmd_out), 32'd0);
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'h77, 1'b0, 1'b0);
            check_all("held_over_reset");
        end
        cyc(1'b0, 8'h77, 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 1'b0, 1'b0);
        check_all("repush");
        compare("repush count", 32'(count), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Overflow set beats clear.
        for (int i = 0; i < 4; i++) push(snd_cmd_t'(8'hE0 + i));
        cyc(1'b1, 8'hEE, 1'b0, 1'b1);
        check_all("set_vs_clear");
        compare("set beats clear", 32'(overflow), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        check_all("clear_alone");
        compare("clear alone", 32'(overflow), 32'd0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 1)), snd_cmd_t'($urandom()),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
            check_all("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
